// File: rtl/dec2bin_seq.sv
// rtl/dec2bin_seq.sv - sequential packed-BCD to unsigned binary converter (reverse double-dabble)
module dec2bin_seq #(
  parameter int NUM_DIGITS = 3,
  parameter int BIN_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_WIDTH-1:0]    bin_out,
  output logic                    err,
  output logic                    ovf
);

  localparam int N  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         bcd_sr_q, bcd_sr_d;
  logic [N-1:0]         bin_sr_q, bin_sr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] bin_out_q, bin_out_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;

  logic [N-1:0]         bcd_shift;
  logic [N-1:0]         bcd_adj;
  logic [N-1:0]         bin_shift;
  logic                 bad_digit;
  logic                 ovf_next;
  logic                 last_step;

  // One reverse double-dabble step: shift the pair right, then pull every digit >= 8 back by 3
  always_comb begin
    bcd_shift = {1'b0, bcd_sr_q[N-1:1]};
    bin_shift = {bcd_sr_q[0], bin_sr_q[N-1:1]};
    bcd_adj   = bcd_shift;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_shift[4*i +: 4] >= 4'd8) begin
        bcd_adj[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
      end
    end
  end

  // Flag any captured digit outside 0..9
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_sr_q[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Bits of the full result that do not fit in bin_out signal overflow
  generate
    if (BIN_WIDTH < N) begin : g_ovf
      assign ovf_next = |bin_shift[N-1:BIN_WIDTH];
    end else begin : g_no_ovf
      assign ovf_next = 1'b0;
    end
  endgenerate

  assign last_step = (cnt_q == CW'(N - 1));

  // Next-state and datapath control; everything holds unless a state acts on it
  always_comb begin
    state_d   = state_q;
    bcd_sr_d  = bcd_sr_q;
    bin_sr_d  = bin_sr_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_sr_d = bcd_in;
          bin_sr_d = '0;
          cnt_d    = '0;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_digit) begin
          bin_out_d = '0;
          err_d     = 1'b1;
          ovf_d     = 1'b0;
          state_d   = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_sr_d = bcd_adj;
        bin_sr_d = bin_shift;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          bin_out_d = bin_shift[BIN_WIDTH-1:0];
          ovf_d     = ovf_next;
          err_d     = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bcd_sr_q  <= '0;
      bin_sr_q  <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_sr_q  <= bcd_sr_d;
      bin_sr_q  <= bin_sr_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign busy    = (state_q == S_CHECK) || (state_q == S_SHIFT);
  assign done    = (state_q == S_DONE);
  assign bin_out = bin_out_q;
  assign err     = err_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_dec2bin_seq.sv
// tb/tb_dec2bin_seq.sv - self-checking bench for dec2bin_seq at BIN_WIDTH 10 and 8
module tb_dec2bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;

  logic       ready_a, busy_a, done_a, err_a, ovf_a;
  logic [9:0] bin_a;
  logic       ready_b, busy_b, done_b, err_b, ovf_b;
  logic [7:0] bin_b;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int starts = 0;
  int dones  = 0;

  dec2bin_seq #(.NUM_DIGITS(3), .BIN_WIDTH(10)) u_a (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .ready(ready_a), .busy(busy_a), .done(done_a),
    .bin_out(bin_a), .err(err_a), .ovf(ovf_a)
  );

  dec2bin_seq #(.NUM_DIGITS(3), .BIN_WIDTH(8)) u_b (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .ready(ready_b), .busy(busy_b), .done(done_b),
    .bin_out(bin_b), .err(err_b), .ovf(ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit digits_bad(input logic [11:0] v);
    bit b = 0;
    for (int i = 0; i < 3; i++) begin
      if (((v >> (4*i)) & 12'hF) > 9) b = 1;
    end
    return b;
  endfunction

  function automatic int dec_val(input logic [11:0] v);
    int d0 = int'(v & 12'hF);
    int d1 = int'((v >> 4) & 12'hF);
    int d2 = int'((v >> 8) & 12'hF);
    return d2 * 100 + d1 * 10 + d0;
  endfunction

  // Timeline model: an accepted operand finishes 13 edges later (1 if invalid), then one idle return edge
  bit          m_active, m_done, m_err, m_ovf_a, m_ovf_b;
  int          m_left, m_bin_a, m_bin_b, m_v;
  logic [11:0] m_cap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_done = 0; m_left = 0;
      m_bin_a = 0; m_bin_b = 0; m_err = 0; m_ovf_a = 0; m_ovf_b = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      m_left--;
      if (m_left == 0) begin
        m_active = 0;
        m_done   = 1;
        if (digits_bad(m_cap)) begin
          m_bin_a = 0; m_bin_b = 0; m_err = 1; m_ovf_a = 0; m_ovf_b = 0;
        end else begin
          m_v     = dec_val(m_cap);
          m_err   = 0;
          m_bin_a = m_v % 1024; m_ovf_a = (m_v >= 1024);
          m_bin_b = m_v % 256;  m_ovf_b = (m_v >= 256);
        end
      end
    end else if (start) begin
      m_cap    = bcd_in;
      m_active = 1;
      m_left   = digits_bad(bcd_in) ? 1 : 13;
    end
  end

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (done_a) dones++;
    chk("ready_a", int'(ready_a), int'(!m_active && !m_done));
    chk("busy_a",  int'(busy_a),  int'(m_active));
    chk("done_a",  int'(done_a),  int'(m_done));
    chk("bin_a",   int'(bin_a),   m_bin_a);
    chk("err_a",   int'(err_a),   int'(m_err));
    chk("ovf_a",   int'(ovf_a),   int'(m_ovf_a));
    chk("ready_b", int'(ready_b), int'(!m_active && !m_done));
    chk("busy_b",  int'(busy_b),  int'(m_active));
    chk("done_b",  int'(done_b),  int'(m_done));
    chk("bin_b",   int'(bin_b),   m_bin_b);
    chk("err_b",   int'(err_b),   int'(m_err));
    chk("ovf_b",   int'(ovf_b),   int'(m_ovf_b));
  end

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (ready_a) ok = 1;
    end
    if (!ok) chk("wait_ready_timeout", 0, 1);
  endtask

  task automatic run_conv(input logic [11:0] v, input int exp_val, input bit exp_err,
                          input int exp_lat);
    int lat = 0;
    bit seen = 0;
    wait_ready();
    @(posedge clk); #1;
    start = 1; bcd_in = v; starts++;
    @(posedge clk); #1;
    start = 0; bcd_in = 12'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done_a) seen = 1;
    end
    chk("done_seen", int'(seen), 1);
    chk("latency", lat, exp_lat);
    chk("res_bin10", int'(bin_a), exp_err ? 0 : exp_val % 1024);
    chk("res_err10", int'(err_a), int'(exp_err));
    chk("res_ovf10", int'(ovf_a), int'(!exp_err && exp_val >= 1024));
    chk("res_bin8",  int'(bin_b), exp_err ? 0 : exp_val % 256);
    chk("res_err8",  int'(err_b), int'(exp_err));
    chk("res_ovf8",  int'(ovf_b), int'(!exp_err && exp_val >= 256));
  endtask

  task automatic wait_done(output int t, output int r);
    bit seen = 0;
    t = 0; r = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_a) begin seen = 1; t = cycle; r = int'(bin_a); end
    end
    chk("stream_done_seen", int'(seen), 1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[1000];
    int t1, r1, t2, r2, tmp, j, n;
    logic [11:0] v;

    rst = 0; start = 0; bcd_in = '0;
    #1 rst = 1;
    @(negedge clk);
    chk("rst_ready", int'(ready_a), 1);
    chk("rst_busy",  int'(busy_a),  0);
    chk("rst_done",  int'(done_a),  0);
    chk("rst_bin",   int'(bin_a),   0);
    chk("rst_err",   int'(err_a),   0);
    chk("rst_ovf",   int'(ovf_a),   0);
    @(posedge clk); #1 rst = 0;

    // Directed operands with hand-computed results
    run_conv(12'h999, 999, 0, 13);
    chk("lit_999", int'(bin_a), 'h3E7);
    run_conv(12'h000, 0,   0, 13);
    run_conv(12'h507, 507, 0, 13);
    run_conv(12'h0A5, 0,   1, 1);
    run_conv(12'h256, 256, 0, 13);
    chk("lit_256_b", int'(bin_b), 0);
    chk("lit_256_ovf", int'(ovf_b), 1);
    run_conv(12'h255, 255, 0, 13);
    chk("lit_255_b", int'(bin_b), 255);

    // Start held high; operand changes during the first conversion
    wait_ready();
    @(posedge clk); #1;
    start = 1; bcd_in = 12'h123; starts++;
    repeat (5) @(posedge clk);
    #1 bcd_in = 12'h456;
    wait_done(t1, r1);
    starts++;
    wait_done(t2, r2);
    start = 0;
    chk("stream_first", r1, 123);
    chk("stream_second", r2, 456);
    chk("stream_spacing", t2 - t1, 15);

    // Asynchronous reset during SHIFT step 6
    wait_ready();
    @(posedge clk); #1;
    start = 1; bcd_in = 12'h321;
    @(posedge clk); #1 start = 0;
    repeat (7) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("abort_ready", int'(ready_a), 1);
    chk("abort_busy",  int'(busy_a),  0);
    chk("abort_done",  int'(done_a),  0);
    chk("abort_bin",   int'(bin_a),   0);
    chk("abort_err",   int'(err_a),   0);
    chk("abort_ovf",   int'(ovf_a),   0);
    @(posedge clk); #1 rst = 0;
    run_conv(12'h042, 42, 0, 13);

    // All 1000 valid operands in random order
    for (int i = 0; i < 1000; i++) order[i] = i;
    for (int i = 999; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 1000; i++) begin
      n = order[i];
      v = 12'(((n / 100) << 8) | (((n / 10) % 10) << 4) | (n % 10));
      run_conv(v, n, 0, 13);
    end

    // Random raw 12-bit patterns, valid or not
    for (int i = 0; i < 30; i++) begin
      v = 12'($urandom_range(0, 4095));
      if (digits_bad(v)) run_conv(v, 0, 1, 1);
      else run_conv(v, dec_val(v), 0, 13);
    end

    repeat (3) @(negedge clk);
    chk("done_count", dones, starts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
